// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_counter
// Description : Two-digit BCD down counter with parallel load, BCD-validated
//               load with sticky error flag, terminal-count pulse and
//               selectable wrap (00 -> 99) or hold at 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_counter #(
  parameter int WRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       zero,
  output logic       tc,
  output logic       load_err
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic [7:0] dec_val;
  logic       load_ok;

  assign tens = count[7:4];
  assign ones = count[3:0];

  // A load is accepted only when both nibbles are legal BCD digits.
  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

  // One-step BCD decrement, including the borrow and the terminal-count case.
  always_comb begin
    dec_val = count;
    if (ones != 4'd0) begin
      dec_val = {tens, ones - 4'd1};
    end else if (tens != 4'd0) begin
      dec_val = {tens - 4'd1, 4'd9};
    end else if (WRAP != 0) begin
      dec_val = 8'h99;
    end else begin
      dec_val = 8'h00;
    end
  end

  // Count, load error and terminal-count registers; rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 8'h00;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        if (load_ok) begin
          count    <= load_val;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        count <= dec_val;
        // Only a genuine 01 -> 00 step raises tc; wrap and hold never do.
        tc    <= (count == 8'h01);
      end
    end
  end

  // Zero indication depends on the registered count alone.
  assign zero = (count == 8'h00);

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_down_counter
// Description : Directed self-checking bench for bcd_down_counter, with one
//               instance wrapping (WRAP=1) and one holding (WRAP=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;

  logic [7:0] count_w, count_h;
  logic       zero_w, zero_h;
  logic       tc_w, tc_h;
  logic       err_w, err_h;

  int checks = 0;
  int errors = 0;

  bcd_down_counter #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(count_w), .zero(zero_w), .tc(tc_w), .load_err(err_w)
  );

  bcd_down_counter #(.WRAP(0)) dut_hold (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
    .count(count_h), .zero(zero_h), .tc(tc_h), .load_err(err_h)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs across one rising edge, then settle past it.
  task automatic step(input logic r, input logic l, input logic [7:0] v, input logic e);
    rst = r; load = l; load_val = v; en = e;
    @(posedge clk);
    #1;
  endtask

  // Check the full output set of one instance.
  task automatic chk_all(input string tag, input logic [7:0] c, input logic z, input logic t,
                         input logic le, input logic [7:0] ec, input logic ez,
                         input logic et, input logic ele);
    chk({tag, ".count"}, c, ec);
    chk({tag, ".zero"}, {7'd0, z}, {7'd0, ez});
    chk({tag, ".tc"}, {7'd0, t}, {7'd0, et});
    chk({tag, ".err"}, {7'd0, le}, {7'd0, ele});
  endtask

  initial begin
    logic [7:0] exp_bcd;
    rst = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous load and enable.
    step(1, 1, 8'h55, 1);
    chk_all("rst_w", count_w, zero_w, tc_w, err_w, 8'h00, 1, 0, 0);
    chk_all("rst_h", count_h, zero_h, tc_h, err_h, 8'h00, 1, 0, 0);

    // Load 23 then three decrements.
    step(0, 1, 8'h23, 0);
    chk_all("ld23", count_w, zero_w, tc_w, err_w, 8'h23, 0, 0, 0);
    step(0, 0, 8'h00, 1);
    chk_all("dn22", count_w, zero_w, tc_w, err_w, 8'h22, 0, 0, 0);
    step(0, 0, 8'h00, 1);
    chk_all("dn21", count_w, zero_w, tc_w, err_w, 8'h21, 0, 0, 0);
    step(0, 0, 8'h00, 1);
    chk_all("dn20", count_w, zero_w, tc_w, err_w, 8'h20, 0, 0, 0);

    // Borrow from tens.
    step(0, 1, 8'h10, 0);
    chk("ld10", count_w, 8'h10);
    step(0, 0, 8'h00, 1);
    chk("borrow09", count_w, 8'h09);
    step(0, 0, 8'h00, 1);
    chk("dn08", count_w, 8'h08);

    // Approach zero: tc only in the 00 cycle; then wrap vs hold.
    step(0, 1, 8'h02, 0);
    chk("ld02", count_w, 8'h02);
    step(0, 0, 8'h00, 1);
    chk_all("w01", count_w, zero_w, tc_w, err_w, 8'h01, 0, 0, 0);
    step(0, 0, 8'h00, 1);
    chk_all("w00", count_w, zero_w, tc_w, err_w, 8'h00, 1, 1, 0);
    chk_all("h00", count_h, zero_h, tc_h, err_h, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 1);
    chk_all("w99", count_w, zero_w, tc_w, err_w, 8'h99, 0, 0, 0);
    chk_all("hhold", count_h, zero_h, tc_h, err_h, 8'h00, 1, 0, 0);

    // Hold variant: load 01, then three enables -> single tc pulse.
    step(0, 1, 8'h01, 0);
    chk("h_ld01", count_h, 8'h01);
    step(0, 0, 8'h00, 1);
    chk_all("h_a", count_h, zero_h, tc_h, err_h, 8'h00, 1, 1, 0);
    chk_all("w_a", count_w, zero_w, tc_w, err_w, 8'h00, 1, 1, 0);
    step(0, 0, 8'h00, 1);
    chk_all("h_b", count_h, zero_h, tc_h, err_h, 8'h00, 1, 0, 0);
    chk("w_b", count_w, 8'h99);
    step(0, 0, 8'h00, 1);
    chk_all("h_c", count_h, zero_h, tc_h, err_h, 8'h00, 1, 0, 0);
    chk("w_c", count_w, 8'h98);

    // Loading 00 never raises tc.
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h00, 0);
    chk_all("ld00", count_w, zero_w, tc_w, err_w, 8'h00, 1, 0, 0);

    // Rejected non-BCD load keeps count, sets sticky error.
    step(0, 1, 8'h98, 0);
    step(0, 1, 8'h3A, 0);
    chk_all("bad3A", count_w, zero_w, tc_w, err_w, 8'h98, 0, 0, 1);
    step(0, 0, 8'h00, 0);
    chk_all("sticky", count_w, zero_w, tc_w, err_w, 8'h98, 0, 0, 1);
    step(0, 0, 8'h00, 1);
    chk_all("sticky_en", count_w, zero_w, tc_w, err_w, 8'h97, 0, 0, 1);
    step(0, 1, 8'h05, 0);
    chk_all("ld05", count_w, zero_w, tc_w, err_w, 8'h05, 0, 0, 0);
    step(0, 1, 8'hA1, 0);
    chk_all("badA1", count_w, zero_w, tc_w, err_w, 8'h05, 0, 0, 1);

    // Load and enable together: load only.
    step(0, 1, 8'h42, 1);
    chk_all("ld_en", count_w, zero_w, tc_w, err_w, 8'h42, 0, 0, 0);

    // Mid-count reset with enable high.
    step(0, 1, 8'h50, 0);
    step(0, 0, 8'h00, 1);
    chk("dn49", count_w, 8'h49);
    step(0, 0, 8'h00, 1);
    chk("dn48", count_w, 8'h48);
    step(0, 1, 8'h9F, 0);
    chk("bad9F", {7'd0, err_w}, 8'h01);
    step(1, 0, 8'h00, 1);
    chk_all("rst_mid", count_w, zero_w, tc_w, err_w, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 1);
    chk_all("post_rst", count_w, zero_w, tc_w, err_w, 8'h99, 0, 0, 0);
    chk("post_rst_h", count_h, 8'h00);

    // Full sweep 99 -> 00, one code per cycle.
    step(0, 1, 8'h99, 0);
    chk("sweep_ld", count_w, 8'h99);
    for (int i = 98; i >= 0; i--) begin
      step(0, 0, 8'h00, 1);
      exp_bcd = {4'(i / 10), 4'(i % 10)};
      chk("sweep", count_w, exp_bcd);
      chk("sweep_tc", {7'd0, tc_w}, {7'd0, (i == 0)});
      chk("sweep_h", count_h, exp_bcd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
